// File: rtl/seq_mult.sv
// rtl/seq_mult.sv - sequential add-and-shift multiplier, signed/unsigned per transaction
// Valid/ready on operands and product; one partial-product step per cycle.
module seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [2*WIDTH-1:0]   acc, acc_nxt;
  logic [WIDTH:0]       sum;
  logic [CW-1:0]        cnt;
  logic                 neg;
  logic                 last;

  // Magnitude of the most negative value wraps to itself, which is the correct unsigned magnitude.
  assign a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag = (is_signed && b[WIDTH-1]) ? -b : b;
  assign last  = (cnt == CW'(WIDTH-1));

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Upper half accumulates with carry; lower half holds the remaining multiplier bits.
  always_comb begin
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    acc_nxt = {sum, acc[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      acc     <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand <= a_mag;
            acc   <= {{WIDTH{1'b0}}, b_mag};
            cnt   <= '0;
            neg   <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
          end
        end
        RUN: begin
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
          if (last) begin
            product <= neg ? -acc_nxt : acc_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult.sv
// tb/tb_seq_mult.sv - randomized self-checking bench for seq_mult at WIDTH 4, 8 and 32
// One stimulus set is routed to the instance selected by sel.
module tb_seq_mult;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready, is_signed;
  logic [31:0] a_d, b_d;
  int          sel;

  logic        r4, r8, r32, v4, v8, v32;
  logic [7:0]  p4;
  logic [15:0] p8;
  logic [63:0] p32;
  logic        in_ready_m, out_valid_m;
  logic [63:0] product_m;

  int checks = 0;
  int errors = 0;
  int sent = 0;
  int hs_cnt = 0;

  always #5 clk = ~clk;

  seq_mult #(.WIDTH(4)) u_m4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && (sel == 4)), .in_ready(r4),
    .a(a_d[3:0]), .b(b_d[3:0]), .is_signed(is_signed),
    .out_valid(v4), .out_ready(out_ready), .product(p4)
  );

  seq_mult #(.WIDTH(8)) u_m8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && (sel == 8)), .in_ready(r8),
    .a(a_d[7:0]), .b(b_d[7:0]), .is_signed(is_signed),
    .out_valid(v8), .out_ready(out_ready), .product(p8)
  );

  seq_mult #(.WIDTH(32)) u_m32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && (sel == 32)), .in_ready(r32),
    .a(a_d), .b(b_d), .is_signed(is_signed),
    .out_valid(v32), .out_ready(out_ready), .product(p32)
  );

  always_comb begin
    in_ready_m  = r32;
    out_valid_m = v32;
    product_m   = p32;
    if (sel == 4) begin
      in_ready_m  = r4;
      out_valid_m = v4;
      product_m   = {56'd0, p4};
    end else if (sel == 8) begin
      in_ready_m  = r8;
      out_valid_m = v8;
      product_m   = {48'd0, p8};
    end
  end

  always @(posedge clk) begin
    if (rst_n && out_valid_m && out_ready) hs_cnt <= hs_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (w=%0d): got %0h expected %0h", tag, sel, got, exp);
    end
  endtask

  // Sign-extend to 64 bits, multiply modulo 2^64, keep 2*w bits.
  function automatic logic [63:0] ref_mult(input int w, input logic [31:0] av,
                                           input logic [31:0] bv, input bit s);
    logic [63:0] m, ea, eb, p;
    m  = (64'd1 << w) - 64'd1;
    ea = {32'd0, av} & m;
    eb = {32'd0, bv} & m;
    if (s && ea[w-1]) ea = ea | ~m;
    if (s && eb[w-1]) eb = eb | ~m;
    p = ea * eb;
    if (w < 32) p = p & ((64'd1 << (2 * w)) - 64'd1);
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input logic [31:0] av, input logic [31:0] bv, input bit s,
                         input int hold, input bit junk);
    int          n;
    bit          bad;
    logic [63:0] exp, held;
    exp       = ref_mult(sel, av, bv, s);
    a_d       = av;
    b_d       = bv;
    is_signed = s;
    in_valid  = 1'b1;
    n = 0;
    while (!in_ready_m && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check("accept_timeout", 64'(n), 64'(0));
    tick();
    in_valid = 1'b0;
    n   = 0;
    bad = 1'b0;
    while (!out_valid_m && n < 100) begin
      if (in_ready_m) bad = 1'b1;
      if (junk) begin
        in_valid  = 1'($urandom);
        a_d       = $urandom;
        b_d       = $urandom;
        is_signed = ~s;
      end
      tick();
      n++;
    end
    in_valid = 1'b0;
    check("latency", 64'(n), 64'(sel));
    check("product", product_m, exp);
    check("in_ready_busy", 64'(bad), 64'(0));
    if (hold > 0) begin
      out_ready = 1'b0;
      held      = product_m;
      bad       = 1'b0;
      repeat (hold) begin
        if (junk) begin
          in_valid = 1'($urandom);
          a_d      = $urandom;
          b_d      = $urandom;
        end
        tick();
        if (!out_valid_m || in_ready_m || product_m !== held) bad = 1'b1;
      end
      in_valid = 1'b0;
      check("hold_stable", 64'(bad), 64'(0));
    end
    out_ready = 1'b1;
    tick();
    check("in_ready_after", {62'd0, in_ready_m, out_valid_m}, 64'd2);
    sent++;
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  hs0;
    bit  bad;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    is_signed = 1'b0;
    a_d       = '0;
    b_d       = '0;
    sel       = 8;
    #12;
    check("reset_in_ready", 64'(in_ready_m), 64'(1));
    check("reset_out_valid", 64'(out_valid_m), 64'(0));
    check("reset_product", product_m, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run_txn(32'h0F, 32'h0D, 1'b0, 0, 1'b0);
    check("directed_c3", product_m, 64'h00C3);
    run_txn(32'hFF, 32'hFF, 1'b0, 0, 1'b0);
    check("directed_fe01", product_m, 64'hFE01);
    run_txn(32'h80, 32'h80, 1'b1, 0, 1'b0);
    check("directed_4000", product_m, 64'h4000);
    run_txn(32'hFD, 32'h05, 1'b1, 0, 1'b0);
    check("directed_fff1", product_m, 64'hFFF1);

    hs0 = hs_cnt;
    run_txn(32'hA5, 32'h3C, 1'b1, 20, 1'b1);
    check("one_handshake", 64'(hs_cnt), 64'(hs0 + 1));
    bad = 1'b0;
    repeat (12) begin
      tick();
      if (out_valid_m) bad = 1'b1;
    end
    check("no_extra_output", 64'(bad), 64'(0));

    a_d       = 32'h7F;
    b_d       = 32'h7F;
    is_signed = 1'b0;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #2;
    check("abort_out_valid", 64'(out_valid_m), 64'(0));
    check("abort_product", product_m, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (12) begin
      tick();
      if (out_valid_m) bad = 1'b1;
    end
    check("abort_no_output", 64'(bad), 64'(0));
    check("abort_in_ready", 64'(in_ready_m), 64'(1));
    check("abort_product_idle", product_m, 64'd0);
    run_txn(32'h02, 32'h03, 1'b0, 0, 1'b0);
    check("after_abort", product_m, 64'h0006);

    repeat (200) run_txn($urandom, $urandom, 1'($urandom), $urandom_range(0, 3), 1'($urandom));

    sel = 4;
    tick();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 16; i++)
        for (int j = 0; j < 16; j++)
          run_txn(32'(i), 32'(j), s[0], 0, 1'b0);

    sel = 32;
    tick();
    run_txn(32'h80000000, 32'h80000000, 1'b1, 0, 1'b0);
    check("w32_min_sq", product_m, 64'h4000000000000000);
    run_txn(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0, 1'b0);
    check("w32_max_sq", product_m, 64'hFFFFFFFE00000001);
    repeat (1000) begin
      logic [31:0] ra, rb;
      ra = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      run_txn(ra, rb, 1'($urandom), $urandom_range(0, 3), 1'b0);
    end

    repeat (3) tick();
    check("handshake_count", 64'(hs_cnt), 64'(sent));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
